// File: rtl/multiport_sram_pkg.sv
// Shared definitions for the banked multiport sample memory: address-split
// helpers, index-width helpers and the power-of-2 parameter check.
package multiport_sram_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_BANK_SIZE  = 1024;
   localparam int DEF_N_BANKS    = 8;
   localparam int DEF_N_PORTS    = 4;
   localparam int DEF_OFF_W      = $clog2(DEF_BANK_SIZE);
   localparam int DEF_BANK_W     = $clog2(DEF_N_BANKS);
   localparam int DEF_PORT_W     = $clog2(DEF_N_PORTS);
   localparam int DEF_ADDR_WIDTH = DEF_OFF_W + DEF_BANK_W + 1;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   // Signal widths never drop to zero, even for a single bank or port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned offset_of(input logic [31:0] addr, input int off_bits);
      return addr & ((32'd1 << off_bits) - 32'd1);
   endfunction

   function automatic int unsigned bank_of(input logic [31:0] addr, input int off_bits,
                                           input int bank_bits);
      return (addr >> off_bits) & ((32'd1 << bank_bits) - 32'd1);
   endfunction

   function automatic logic in_range(input logic [31:0] addr, input int off_bits,
                                     input int bank_bits);
      return (addr >> (off_bits + bank_bits)) == 32'd0;
   endfunction

endpackage

// File: rtl/multiport_sram_if.sv
// Request/response bundle between the requesters (master) and the memory (slave).
interface multiport_sram_if
   import multiport_sram_pkg::*;
#(
   parameter int N_PORTS    = DEF_N_PORTS,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic [N_PORTS-1:0]                 req_valid;
   logic [N_PORTS-1:0]                 req_ready;
   logic [N_PORTS-1:0]                 req_write;
   logic [N_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [N_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
   logic [N_PORTS-1:0]                 rsp_valid;
   logic [N_PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata;
   logic [N_PORTS-1:0]                 rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/multiport_sram_bank.sv
// One single-ported bank: a write or a registered read per cycle when en is high.
module sram_bank_1rw #(
   parameter int DATA_WIDTH = 16,
   parameter int AW         = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [0:(1<<AW)-1];

   // No reset: contents and the read register survive reset by design.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end
endmodule

// File: rtl/multiport_sram.sv
// Banked sample memory with per-bank round-robin arbitration and a fixed
// two-edge response pipeline. MULTIPORT_SRAM_RANGE_CHECK_EN enables out-of-range errors.
module multiport_sram
   import multiport_sram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BANK_SIZE  = DEF_BANK_SIZE,
   parameter int N_BANKS    = DEF_N_BANKS,
   parameter int N_PORTS    = DEF_N_PORTS,
   parameter int ADDR_WIDTH = $clog2(BANK_SIZE*N_BANKS) + 1
) (
   input logic             clk,
   input logic             reset,
   multiport_sram_if.slave bus
);
   localparam int OFF_BITS  = $clog2(BANK_SIZE);
   localparam int BANK_BITS = $clog2(N_BANKS);
   localparam int OFF_W     = idx_w(BANK_SIZE);
   localparam int BK_W      = idx_w(N_BANKS);
   localparam int PT_W      = idx_w(N_PORTS);
   localparam int STAGES    = 2;

   if (!is_pow2(BANK_SIZE)) begin : g_bad_bank_size
      $error("multiport_sram: BANK_SIZE must be a power of 2");
   end
   if (!is_pow2(N_BANKS)) begin : g_bad_n_banks
      $error("multiport_sram: N_BANKS must be a power of 2");
   end

   logic [N_PORTS-1:0]           in_r;
   logic [N_PORTS-1:0][BK_W-1:0] p_bank;
   logic [N_PORTS-1:0][OFF_W-1:0] p_off;

   always_comb begin
      in_r   = '1;
      p_bank = '0;
      p_off  = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         p_off[p]  = OFF_W'(offset_of(32'(bus.req_addr[p]), OFF_BITS));
         p_bank[p] = BK_W'(bank_of(32'(bus.req_addr[p]), OFF_BITS, BANK_BITS));
`ifdef MULTIPORT_SRAM_RANGE_CHECK_EN
         in_r[p]   = in_range(32'(bus.req_addr[p]), OFF_BITS, BANK_BITS);
`endif
      end
   end

   logic [N_BANKS-1:0][PT_W-1:0] rr;
   logic [N_BANKS-1:0][PT_W-1:0] gnt_port;
   logic [N_BANKS-1:0]           gnt_any;
   logic [N_PORTS-1:0]           grant;

   // Per bank: first requesting port at or after rr[b], wrapping upward.
   always_comb begin
      int p;
      p        = 0;
      gnt_any  = '0;
      gnt_port = '0;
      grant    = '0;
      for (int b = 0; b < N_BANKS; b++) begin
         for (int i = 0; i < N_PORTS; i++) begin
            p = (int'(rr[b]) + i) % N_PORTS;
            if (!gnt_any[b] && bus.req_valid[p] && in_r[p] && int'(p_bank[p]) == b) begin
               gnt_any[b]  = 1'b1;
               gnt_port[b] = PT_W'(p);
               grant[p]    = 1'b1;
            end
         end
      end
   end

   // Out-of-range requests bypass the banks and are always ready.
   logic [N_PORTS-1:0] acc;
   assign bus.req_ready = grant | ~in_r;
   assign acc           = bus.req_valid & bus.req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr <= '0;
      else begin
         for (int b = 0; b < N_BANKS; b++)
            if (gnt_any[b]) rr[b] <= PT_W'((int'(gnt_port[b]) + 1) % N_PORTS);
      end
   end

   logic [N_BANKS-1:0][DATA_WIDTH-1:0] b_rdata;

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      sram_bank_1rw #(.DATA_WIDTH(DATA_WIDTH), .AW(OFF_W)) u_bank (
         .clk   (clk),
         .en    (gnt_any[b]),
         .we    (bus.req_write[gnt_port[b]]),
         .addr  (p_off[gnt_port[b]]),
         .wdata (bus.req_wdata[gnt_port[b]]),
         .rdata (b_rdata[b])
      );
   end

   logic [STAGES:1][N_PORTS-1:0]       vld_pipe;
   logic [N_PORTS-1:0]                 s1_err, s1_rd, rsp_err_q;
   logic [N_PORTS-1:0][BK_W-1:0]       s1_bank;
   logic [N_PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata_q;

   // Stage 1 waits on the bank's registered read; stage 2 muxes it out.
   // With range checking off, in_r is all ones and the error path folds to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe    <= '0;
         s1_err      <= '0;
         s1_rd       <= '0;
         s1_bank     <= '0;
         rsp_err_q   <= '0;
         rsp_rdata_q <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[1], acc};
         s1_err    <= acc & ~in_r;
         s1_rd     <= acc & in_r & ~bus.req_write;
         s1_bank   <= p_bank;
         rsp_err_q <= s1_err;
         for (int p = 0; p < N_PORTS; p++)
            rsp_rdata_q[p] <= s1_rd[p] ? b_rdata[s1_bank[p]] : '0;
      end
   end

   assign bus.rsp_valid = vld_pipe[STAGES];
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_multiport_sram.sv
// Self-checking bench for multiport_sram: directed scenarios plus randomized
// traffic checked against a behavioural memory/arbitration model.
module tb_multiport_sram;
   localparam int NP = 4, NB = 8, BS = 1024, DW = 16, AW = 14;
   localparam int TOTAL = NB * BS;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multiport_sram_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   multiport_sram #(.DATA_WIDTH(DW), .BANK_SIZE(BS), .N_BANKS(NB), .N_PORTS(NP),
                    .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct { int due; int data; bit err; bit known; } exp_t;

   int          ref_mem [int];
   int          rr_m [NB];
   exp_t        expq [NP][$];
   int          cyc = 0;
   bit [NP-1:0] exp_rdy, acc_m, exp_v, exp_e, exp_k;
   int          exp_d [NP];
   int          total = 0, bad = 0;

`ifdef MULTIPORT_SRAM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   function automatic bit in_rng(input int a);
      return RC ? (a < TOTAL) : (a >= 0);
   endfunction
   function automatic int phys(input int a);  return a % TOTAL;      endfunction
   function automatic int bank_m(input int a); return phys(a) / BS;  endfunction

   // Grant rule: per bank, first valid in-range port at or after rr, wrapping.
   function automatic void model_ready();
      exp_rdy = '0;
      for (int p = 0; p < NP; p++)
         if (!in_rng(int'(bus.req_addr[p]))) exp_rdy[p] = 1'b1;
      for (int b = 0; b < NB; b++) begin
         bit found = 1'b0;
         for (int i = 0; i < NP; i++) begin
            int p = (rr_m[b] + i) % NP;
            int a = int'(bus.req_addr[p]);
            if (!found && bus.req_valid[p] && in_rng(a) && bank_m(a) == b) begin
               exp_rdy[p] = 1'b1;
               found = 1'b1;
            end
         end
      end
   endfunction

   task automatic model_clear();
      for (int p = 0; p < NP; p++) expq[p].delete();
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
   endtask

   task automatic set_req(input int p, input bit v, input bit w, input int a, input int d);
      bus.req_valid[p] = v;
      bus.req_write[p] = w;
      bus.req_addr[p]  = AW'(a);
      bus.req_wdata[p] = DW'(d);
   endtask

   task automatic clear_reqs();
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   // Advance one edge: update the model, expose due responses, drop accepted requests.
   task automatic edge_step();
      model_ready();
      @(posedge clk);
      cyc++;
      acc_m = reset ? '0 : (bus.req_valid & exp_rdy);
      for (int p = 0; p < NP; p++) begin
         exp_v[p] = 0; exp_e[p] = 0; exp_k[p] = 1; exp_d[p] = 0;
         if (expq[p].size() > 0 && expq[p][0].due == cyc) begin
            exp_t e = expq[p].pop_front();
            exp_v[p] = 1; exp_e[p] = e.err; exp_k[p] = e.known; exp_d[p] = e.data;
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (acc_m[p]) begin
            exp_t e;
            int   a = int'(bus.req_addr[p]);
            e.due = cyc + 1; e.err = !in_rng(a); e.known = 1; e.data = 0;
            if (!e.err) begin
               if (bus.req_write[p]) ref_mem[phys(a)] = int'(bus.req_wdata[p]);
               else if (ref_mem.exists(phys(a))) e.data = ref_mem[phys(a)];
               else e.known = 0;
               rr_m[bank_m(a)] = (p + 1) % NP;
            end
            expq[p].push_back(e);
         end
      end
      #1;
      bus.req_valid &= ~acc_m;
   endtask

   task automatic test_reset();
      clear_reqs();
      reset = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
      total++; if (bus.rsp_err !== '0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err); end
      total++; if (bus.rsp_rdata !== '0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", bus.rsp_rdata); end
      @(negedge clk);
      reset = 1'b0;
      set_req(0, 1, 1, 100, 16'h0abc);
      #1;
      total++; if (bus.req_ready[0] !== 1'b1) begin bad++; $display("FAIL first_after_reset_ready got=%b want=1", bus.req_ready[0]); end
      edge_step();
      edge_step();
      total++; if (bus.rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL first_after_reset_rsp got=%b want=1", bus.rsp_valid[0]); end
   endtask

   task automatic test_single_port();
      set_req(0, 1, 1, 5, 16'h1234);
      #1;
      total++; if (bus.req_ready[0] !== 1'b1) begin bad++; $display("FAIL single_wr_ready got=%b want=1", bus.req_ready[0]); end
      edge_step();
      set_req(0, 1, 0, 5, 0);
      #1;
      total++; if (bus.req_ready[0] !== 1'b1) begin bad++; $display("FAIL single_rd_ready got=%b want=1", bus.req_ready[0]); end
      edge_step();
      total++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_rdata[0] !== 16'h0 || bus.rsp_err[0] !== 1'b0) begin
         bad++; $display("FAIL single_wr_rsp got v=%b d=%h e=%b want v=1 d=0 e=0", bus.rsp_valid[0], bus.rsp_rdata[0], bus.rsp_err[0]);
      end
      edge_step();
      total++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_rdata[0] !== 16'h1234 || bus.rsp_err[0] !== 1'b0) begin
         bad++; $display("FAIL single_rd_rsp got v=%b d=%h e=%b want v=1 d=1234 e=0", bus.rsp_valid[0], bus.rsp_rdata[0], bus.rsp_err[0]);
      end
      edge_step();
      total++; if (bus.rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL single_one_pulse got=%b want=0", bus.rsp_valid[0]); end
   endtask

   task automatic test_contention();
      for (int p = 0; p < NP; p++) set_req(p, 1, 0, 2*BS + p, 0);
      for (int k = 0; k < NP; k++) begin
         logic [NP-1:0] want = NP'(1) << k;
         #1;
         total++; if (bus.req_ready !== want) begin bad++; $display("FAIL contention_order%0d got=%b want=%b", k, bus.req_ready, want); end
         edge_step();
      end
      set_req(3, 1, 0, 2*BS + 3, 0);
      set_req(0, 1, 0, 2*BS, 0);
      #1;
      total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL contention_wrap0 got=%b want=0001", bus.req_ready); end
      edge_step();
      #1;
      total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL contention_wrap3 got=%b want=1000", bus.req_ready); end
      edge_step();
      edge_step();
      edge_step();
   endtask

   task automatic test_parallel();
      for (int p = 0; p < NP; p++) set_req(p, 1, 0, p*BS + 7, 0);
      #1;
      total++; if (bus.req_ready !== 4'b1111) begin bad++; $display("FAIL parallel_ready got=%b want=1111", bus.req_ready); end
      edge_step();
      edge_step();
      total++; if (bus.rsp_valid !== 4'b1111) begin bad++; $display("FAIL parallel_rsp got=%b want=1111", bus.rsp_valid); end
      edge_step();
   endtask

   task automatic test_raw();
      set_req(0, 1, 1, 'h40, 16'hBEEF);
      #1;
      edge_step();
      set_req(1, 1, 0, 'h40, 0);
      #1;
      total++; if (bus.req_ready[1] !== 1'b1) begin bad++; $display("FAIL raw_ready got=%b want=1", bus.req_ready[1]); end
      edge_step();
      edge_step();
      total++; if (bus.rsp_valid[1] !== 1'b1 || bus.rsp_rdata[1] !== 16'hBEEF) begin
         bad++; $display("FAIL raw_data got v=%b d=%h want v=1 d=beef", bus.rsp_valid[1], bus.rsp_rdata[1]);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 16; i++) begin
         if (i < 8)       set_req(2, 1, 1, 3*BS + i, 16'h1000 + i*16'h0111);
         else if (i < 16) set_req(2, 1, 0, 3*BS + (i - 8), 0);
         #1;
         if (i < 16) begin
            total++; if (bus.req_ready[2] !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, bus.req_ready[2]); end
         end
         edge_step();
         if (i >= 1) begin
            logic [DW-1:0] want = (i - 1 >= 8) ? DW'(16'h1000 + (i - 9)*16'h0111) : '0;
            total++; if (bus.rsp_valid[2] !== 1'b1 || bus.rsp_rdata[2] !== want) begin
               bad++; $display("FAIL b2b_rsp%0d got v=%b d=%h want v=1 d=%h", i, bus.rsp_valid[2], bus.rsp_rdata[2], want);
            end
         end
      end
   endtask

   task automatic test_range();
      set_req(0, 1, 1, 0, 16'hA0A0);
      edge_step();
      set_req(0, 1, 1, TOTAL, 16'h5555);
      #1;
      total++; if (bus.req_ready[0] !== 1'b1) begin bad++; $display("FAIL range_wr_ready got=%b want=1", bus.req_ready[0]); end
      edge_step();
      set_req(0, 1, 0, TOTAL, 0);
      #1;
      edge_step();
      total++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_err[0] !== RC || bus.rsp_rdata[0] !== 16'h0) begin
         bad++; $display("FAIL range_wr_rsp got v=%b e=%b d=%h want v=1 e=%b d=0", bus.rsp_valid[0], bus.rsp_err[0], bus.rsp_rdata[0], RC);
      end
      set_req(0, 1, 0, 0, 0);
      #1;
      edge_step();
      begin
         logic [DW-1:0] want = RC ? 16'h0 : 16'h5555;
         total++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_err[0] !== RC || bus.rsp_rdata[0] !== want) begin
            bad++; $display("FAIL range_rd_rsp got v=%b e=%b d=%h want v=1 e=%b d=%h", bus.rsp_valid[0], bus.rsp_err[0], bus.rsp_rdata[0], RC, want);
         end
      end
      edge_step();
      begin
         logic [DW-1:0] want = RC ? 16'hA0A0 : 16'h5555;
         total++; if (bus.rsp_rdata[0] !== want || bus.rsp_err[0] !== 1'b0) begin
            bad++; $display("FAIL range_alias_mem got d=%h e=%b want d=%h e=0", bus.rsp_rdata[0], bus.rsp_err[0], want);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (c < 390 && !bus.req_valid[p] && $urandom_range(0, 3) != 0) begin
               int a = ($urandom_range(0, 15) == 0) ? TOTAL + int'($urandom_range(0, 2*BS))
                                                    : int'($urandom_range(0, NB-1))*BS + int'($urandom_range(0, 3));
               set_req(p, 1, $urandom_range(0, 1) == 1, a, int'($urandom_range(0, 65535)));
            end
         end
         #1;
         model_ready();
         total++; if ((bus.req_ready & bus.req_valid) !== (exp_rdy & bus.req_valid)) begin
            bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, bus.req_ready & bus.req_valid, exp_rdy & bus.req_valid);
         end
         edge_step();
         for (int p = 0; p < NP; p++) begin
            total++;
            if (bus.rsp_valid[p] !== exp_v[p] ||
                (exp_v[p] && (bus.rsp_err[p] !== exp_e[p] ||
                              (exp_k[p] && bus.rsp_rdata[p] !== DW'(exp_d[p]))))) begin
               bad++; $display("FAIL rand_rsp c=%0d p=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                               c, p, bus.rsp_valid[p], bus.rsp_err[p], bus.rsp_rdata[p], exp_v[p], exp_e[p], DW'(exp_d[p]));
            end
         end
      end
   endtask

   task automatic test_reset_inflight();
      clear_reqs();
      for (int p = 0; p < 3; p++) set_req(p, 1, 0, p*BS + 'h40, 0);
      #1;
      edge_step();
      for (int p = 0; p < 3; p++) set_req(p, 1, 0, p*BS + 'h40, 0);
      #1;
      edge_step();
      total++; if (bus.rsp_valid[2:0] !== 3'b111) begin bad++; $display("FAIL inflight_pre got=%b want=111", bus.rsp_valid[2:0]); end
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL inflight_async_drop got=%b want=0", bus.rsp_valid); end
      clear_reqs();
      @(negedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         edge_step();
         total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL inflight_stale%0d got=%b want=0", i, bus.rsp_valid); end
      end
      set_req(3, 1, 0, 'h40, 0);
      #1;
      edge_step();
      edge_step();
      total++; if (bus.rsp_valid[3] !== 1'b1 || bus.rsp_rdata[3] !== 16'hBEEF) begin
         bad++; $display("FAIL inflight_mem_kept got v=%b d=%h want v=1 d=beef", bus.rsp_valid[3], bus.rsp_rdata[3]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_reqs();
      test_reset();
      test_single_port();
      test_contention();
      test_parallel();
      test_raw();
      test_back_to_back();
      test_range();
      test_random();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multiport_sram.md
# multiport_sram

Banked on-chip sample memory shared by `N_PORTS` independent requesters, each with a valid/ready request channel and a fixed-latency response channel. Every bank is single-ported and serves at most one request per cycle. Each bank arbitrates round-robin among the ports addressing it, so ports that hit different banks proceed in parallel. The block sits between the DSP pipeline stages (delay lines, coefficient fetch, host loader) and the physical RAM, and replaces the single-requester contiguous memory.

## Interface
- `DATA_WIDTH`, 16: word width.
- `BANK_SIZE`, 1024: words per bank; must be a power of 2 (non-power-of-2 is a compile-time error).
- `N_BANKS`, 8: bank count; power of 2, ≥ 1.
- `N_PORTS`, 4: requester count, ≥ 1.
- `ADDR_WIDTH`, `$clog2(BANK_SIZE*N_BANKS)+1`: request address width; the one extra bit allows out-of-range detection.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in `N_PORTS`: request present, one bit per port.
- `req_ready` out `N_PORTS`: request granted this cycle; combinational from `req_valid`, address bits and arbiter state.
- `req_write` in `N_PORTS`: 1 = write, 0 = read.
- `req_addr` in `N_PORTS*ADDR_WIDTH`: packed per-port word address.
- `req_wdata` in `N_PORTS*DATA_WIDTH`: packed per-port write data.
- `rsp_valid` out `N_PORTS`: one-cycle response pulse per port.
- `rsp_rdata` out `N_PORTS*DATA_WIDTH`: read data; 0 for writes and for errored requests.
- `rsp_err` out `N_PORTS`: qualifies `rsp_valid`; the request was out of range.

## Operation
- Address split:
  - bank offset = `addr[log2(BANK_SIZE)-1:0]`;
  - bank index = the next `log2(N_BANKS)` bits;
  - any set bit above those marks the request out of range.
- Each bank keeps a round-robin pointer `rr[b]` (width `log2(N_PORTS)`).
  - Among ports with `req_valid` and in-range addresses targeting bank b, the grant goes to the first port at or after `rr[b]`, scanning upward and wrapping.
  - On a grant to port p, `rr[b]` becomes p+1 mod `N_PORTS`. If bank b grants nothing, `rr[b]` holds.
- Out-of-range requests never touch a bank and are always accepted in the cycle they are presented (`req_ready`=1).
- A request is accepted when `req_valid & req_ready` is sampled at a clock edge. Every accepted request produces exactly one `rsp_valid` pulse on its port, including writes. Responses on a port return in acceptance order.
- A write commits to the bank at the acceptance edge.
- A port holds its request stable until accepted. `req_ready` never depends on `rsp_*`.
- Reset values:
  - `rsp_valid`, `rsp_err` and `rsp_rdata` are 0;
  - all `rr` pointers are 0;
  - the in-flight pipeline is cleared, and responses for requests in flight when reset asserts are dropped;
  - memory contents are not cleared.

## Timing
- Acceptance at edge t gives `rsp_valid` high for the cycle after edge t+1 (2-edge latency). Latency is fixed for all ports, banks and error cases.
- Read-after-write to the same address in consecutive cycles (write accepted at edge t, read accepted at t+1) returns the new data.
- The bank is single-ported, so a same-cycle read and write to one bank cannot both be granted.
- A port may be accepted every cycle (throughput 1/port/cycle) when uncontested.
- Simultaneous requests from k ports to one bank: all k are served within k consecutive cycles, with no starvation.
- When reset deasserts, the first request can be accepted at the first following edge.

## Configuration
- `MULTIPORT_SRAM_RANGE_CHECK_EN`:
  - Defined: out-of-range behaviour is as described above. Writes are dropped; the response carries `rsp_err`=1 and `rsp_rdata`=0.
  - Not defined: the bits above the bank index are ignored (address wraps modulo `BANK_SIZE*N_BANKS`), and `rsp_err` is tied to 0.

## Structure
- Package `multiport_sram_pkg`:
  - address-split helper functions (`bank_of`, `offset_of`, `in_range`);
  - localparams for offset/bank/port index widths;
  - the power-of-2 check function.
- Sub-module `sram_bank_1rw`: one bank with a single read/write port, `en`/`we`, and a registered read output; instantiated `N_BANKS` times.
- The top level holds the per-bank arbiters, the 2-stage response pipeline per port (valid, err, bank index), and the output mux.

## Test plan
- Single port 0: write 0x1234 @ addr 5, then read @ 5 → `rsp_valid` 2 edges after each accept; read returns 0x1234, `rsp_err`=0.
- Ports 0–3 all read bank 2 in the same cycle with `rr`=0 → accepted in order 0,1,2,3 over 4 cycles; then ports 3 and 0 contend → 0 granted first (`rr`=0 after granting 3).
- Ports 0–3 read banks 0–3 respectively in one cycle → all `req_ready`=1, all 4 responses in the same cycle.
- Write 0xBEEF @ 0x40 accepted at edge t, read @ 0x40 from another port at t+1 → returns 0xBEEF.
- Address 8192 (8 banks of 1024): with the macro → accepted immediately, `rsp_err`=1, `rsp_rdata`=0, memory unchanged; without it → aliases addr 0.
- Assert `reset` asynchronously while 3 reads are in flight → `rsp_valid` falls immediately, no stale responses after release, and data written earlier is still readable.
